// File: rtl/mdu_pkg.sv
// Shared M-unit definitions: widths, divider states and
// division constants used by the divider and its callers.
package mdu_pkg;

  localparam int XLEN = 32;
  localparam int DIV_ITER = 32;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/divider_unsigned_if.sv
// Start/done operand and result bundle between the M-unit
// wrapper (master) and the unsigned divider (slave).
interface divider_unsigned_if;
  import mdu_pkg::*;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            start;
  logic            a31_bit_i;
  logic            b31_bit_i;
  logic            a31_bit_o;
  logic            b31_bit_o;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            done;

  modport master (
    output a, b, start, a31_bit_i, b31_bit_i,
    input  a31_bit_o, b31_bit_o, quotient, remainder, done
  );

  modport slave (
    input  a, b, start, a31_bit_i, b31_bit_i,
    output a31_bit_o, b31_bit_o, quotient, remainder, done
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift in the next dividend
// bit and keep the trial difference when it does not underflow.
import mdu_pkg::*;

module div_restore_step (
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          unused_rem_msb;

  // Remainder stays below the divisor, so its top bit is always 0
  assign unused_rem_msb = rem_i[XLEN];
  assign shifted = {rem_i[XLEN-1:0], bit_i};
  assign diff    = shifted - {1'b0, div_i};
  assign q_bit_o = (shifted >= {1'b0, div_i});
  assign rem_o   = q_bit_o ? diff : shifted;

endmodule

// File: rtl/divider_unsigned.sv
// Iterative 32-bit unsigned restoring divider, one quotient
// bit per cycle, with sign sidebands passed through for the wrapper.
import mdu_pkg::*;

module divider_unsigned (
  input  logic               clk_i,
  input  logic               rst_i,
  divider_unsigned_if.slave  bus
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  div_state_e      state_q;
  logic [4:0]      cnt_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] q_q;
  logic [XLEN-1:0] b_q;
  logic            a31_q;
  logic            b31_q;
  logic [XLEN-1:0] quot_out_q;
  logic [XLEN-1:0] rem_out_q;
  logic            a31_out_q;
  logic            b31_out_q;
  logic            done_q;

  logic [XLEN:0]   rem_d;
  logic            q_bit_d;

  div_restore_step u_step (
    .rem_i   (rem_q),
    .bit_i   (q_q[XLEN-1]),
    .div_i   (b_q),
    .rem_o   (rem_d),
    .q_bit_o (q_bit_d)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      q_q        <= '0;
      b_q        <= '0;
      a31_q      <= 1'b0;
      b31_q      <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      a31_out_q  <= 1'b0;
      b31_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            b_q     <= bus.b;
            q_q     <= bus.a;
            rem_q   <= '0;
            cnt_q   <= '0;
            a31_q   <= bus.a31_bit_i;
            b31_q   <= bus.b31_bit_i;
            state_q <= (bus.b == '0) ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (!bus.start) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            q_q   <= {q_q[XLEN-2:0], q_bit_d};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Divide by zero never iterates, so q_q still holds the dividend
          if (b_q == '0) begin
            quot_out_q <= DIV_BY_ZERO_Q;
            rem_out_q  <= q_q;
          end else begin
            quot_out_q <= q_q;
            rem_out_q  <= rem_q[XLEN-1:0];
          end
          a31_out_q <= a31_q;
          b31_out_q <= b31_q;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.quotient  = quot_out_q;
  assign bus.remainder = rem_out_q;
  assign bus.a31_bit_o = a31_out_q;
  assign bus.b31_bit_o = b31_out_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_divider_unsigned.sv
// Directed scoreboard bench for divider_unsigned: latency,
// divide by zero, abort, reset, back-to-back and sideband capture.
module tb_divider_unsigned;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        a31;
    logic        b31;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   edges;
  int   highs;
  exp_t exp_q[$];

  divider_unsigned_if bus ();

  divider_unsigned dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [31:0] q, input logic [31:0] r,
                      input logic a31, input logic b31);
    exp_t e;
    e.q = q;
    e.r = r;
    e.a31 = a31;
    e.b31 = b31;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic a31, input logic b31);
    bus.a = a;
    bus.b = b;
    bus.a31_bit_i = a31;
    bus.b31_bit_i = b31;
    bus.start = 1'b1;
  endtask

  // edges = index k of the edge Ek after which done is seen (E0 = capture)
  task automatic wait_done(input string tag, input int max, output int e);
    e = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        e = i;
        break;
      end
    end
    checks++;
    assert (e >= 0) else begin
      errors++;
      $error("FAIL %s_timeout observed=none expected=done", tag);
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_q"}, bus.quotient, e.q);
      chk({tag, "_r"}, bus.remainder, e.r);
      chk({tag, "_a31"}, 32'(bus.a31_bit_o), 32'(e.a31));
      chk({tag, "_b31"}, 32'(bus.b31_bit_o), 32'(e.b31));
    end
  endtask

  task automatic count_done(input int n, output int h);
    h = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) h++;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_q"}, bus.quotient, 32'd0);
    chk({tag, "_r"}, bus.remainder, 32'd0);
    chk({tag, "_a31"}, 32'(bus.a31_bit_o), 32'd0);
    chk({tag, "_b31"}, 32'(bus.b31_bit_o), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.start = 1'b0;
    bus.a31_bit_i = 1'b0;
    bus.b31_bit_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 100 / 7
    push(32'd14, 32'd2, 1'b0, 1'b0);
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    wait_done("div100_7", 60, edges);
    bus.start = 1'b0;
    chk("div100_7_lat", 32'(edges), 32'd33);
    check_result("div100_7");
    @(negedge clk);
    chk("div100_7_pulse", 32'(bus.done), 32'd0);
    @(negedge clk);

    // FFFFFFFF / 1 then 3 / 10 with start held
    push(32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    wait_done("divmax_1", 60, edges);
    chk("divmax_1_lat", 32'(edges), 32'd33);
    check_result("divmax_1");
    push(32'd0, 32'd3, 1'b0, 1'b0);
    bus.a = 32'd3;
    bus.b = 32'd10;
    wait_done("div3_10", 60, edges);
    bus.start = 1'b0;
    chk("b2b_gap", 32'(edges + 1), 32'd34);
    check_result("div3_10");
    repeat (2) @(negedge clk);

    // 5 / 0
    push(32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0);
    issue(32'd5, 32'd0, 1'b0, 1'b0);
    wait_done("div5_0", 10, edges);
    bus.start = 1'b0;
    chk("div5_0_lat", 32'(edges), 32'd1);
    check_result("div5_0");
    @(negedge clk);
    chk("div5_0_pulse", 32'(bus.done), 32'd0);

    // 80000000 / 2, start dropped so E10 samples it low
    issue(32'h8000_0000, 32'd2, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    bus.start = 1'b0;
    count_done(45, highs);
    chk("abort_nodone", 32'(highs), 32'd0);
    chk("abort_hold_q", bus.quotient, 32'hFFFF_FFFF);
    chk("abort_hold_r", bus.remainder, 32'd5);
    chk("abort_hold_a31", 32'(bus.a31_bit_o), 32'd0);
    push(32'h4000_0000, 32'd0, 1'b0, 1'b0);
    issue(32'h8000_0000, 32'd2, 1'b0, 1'b0);
    wait_done("div8k_2", 60, edges);
    bus.start = 1'b0;
    check_result("div8k_2");
    @(negedge clk);

    // 1000 / 3, reset applied at E15 with start still high
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    bus.start = 1'b0;
    count_done(45, highs);
    chk("midreset_nodone", 32'(highs), 32'd0);
    push(32'd333, 32'd1, 1'b0, 1'b0);
    issue(32'd1000, 32'd3, 1'b0, 1'b0);
    wait_done("div1000_3", 60, edges);
    bus.start = 1'b0;
    check_result("div1000_3");
    @(negedge clk);

    // sidebands captured at E0; operands changed afterwards
    push(32'd7, 32'd1, 1'b1, 1'b0);
    issue(32'd50, 32'd7, 1'b1, 1'b0);
    @(negedge clk);
    bus.a = 32'd9999;
    bus.b = 32'd1;
    bus.a31_bit_i = 1'b0;
    bus.b31_bit_i = 1'b1;
    wait_done("sideband", 60, edges);
    bus.start = 1'b0;
    chk("sideband_lat", 32'(edges + 1), 32'd33);
    check_result("sideband");
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_unsigned.md
# divider_unsigned

Iterative 32-bit unsigned radix-2 restoring divider producing quotient and remainder. It is the division counterpart of the multiplier in the M-extension execute path and uses the same start/done handshake and sign-sideband convention. The surrounding M-unit wrapper converts signed operands to magnitudes, passes the original sign bits through `a31_bit_i`/`b31_bit_i`, and applies sign correction to the results after `done`.

## Interface
Parameters:
- none; width fixed at 32 (`XLEN` from package)

Ports:
- `clk_i` in 1: sole clock, rising edge
- `rst_i` in 1: reset, synchronous, active-high
- `a` in 32: dividend (unsigned magnitude)
- `b` in 32: divisor (unsigned magnitude)
- `start` in 1: request level; held high by caller until `done`
- `a31_bit_i` in 1: dividend sign sideband, captured with operands
- `b31_bit_i` in 1: divisor sign sideband, captured with operands
- `a31_bit_o` out 1: captured `a31_bit_i`, registered
- `b31_bit_o` out 1: captured `b31_bit_i`, registered
- `quotient` out 32: registered result
- `remainder` out 32: registered result
- `done` out 1: one-cycle completion pulse

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start`=1 at an edge: capture `a`, `b`, and both sidebands; clear the remainder accumulator (33 bits); load the quotient shift register with `a`; set iteration counter to 0.
  - Next state is CALC, or DONE if `b`==0.
- CALC, one iteration per edge:
  - rem = {rem[31:0], q[31]}; q <<= 1.
  - If rem >= {1'b0,b_lat}: rem -= b_lat and q[0] = 1.
  - After the 32nd iteration (counter==31), go to DONE.
- DONE, one edge:
  - Write `quotient`, `remainder`, `a31_bit_o`, `b31_bit_o`; assert `done`; go to IDLE.
- Divide by zero: `quotient`=32'hFFFF_FFFF, `remainder`=captured `a` (RISC-V semantics). No overflow case exists for unsigned division.
- Abort: `start`=0 during CALC sends the block to IDLE next edge. No `done` is produced and the outputs keep their previous values.
- `start` held high after `done`: a new operation is captured in the following IDLE cycle. The caller must drop `start` in the `done` cycle to avoid a restart.
- Operand inputs are ignored outside the IDLE capture edge.
- Outputs hold the last result until the next DONE write.

## Timing
- Call the capture edge E0.
- Normal latency: iterations on E1..E32, outputs and `done` written at E33. `done` is high for exactly the cycle following E33; start-to-done is 33 cycles.
- Divide by zero: outputs and `done` written at E1; `done` is high for the cycle after E1.
- `done` is never high for more than one consecutive cycle.
- Reset, applied at any state including mid-CALC: next state IDLE, counter 0. `done`, `quotient`, `remainder`, `a31_bit_o`, `b31_bit_o` all 0.
- `rst_i` and `start` high on the same edge: reset wins and nothing is captured.
- No combinational path from any input to any output.

## Structure
- Shared package `mdu_pkg`:
  - `XLEN`=32
  - divider state enum (IDLE/CALC/DONE)
  - `DIV_ITER`=32
  - `DIV_BY_ZERO_Q`=32'hFFFF_FFFF
- One natural sub-module, `div_restore_step`: purely combinational, 33-bit trial subtract. Inputs: partial remainder, next dividend bit, divisor. Outputs: next remainder, quotient bit.
- Top level holds the FSM, counter, latches, and output registers.

## Test plan
- 100 / 7, sidebands 0/0 -> `quotient`=14, `remainder`=2, `done` pulse 33 cycles after the capture edge, one cycle wide.
- 32'hFFFF_FFFF / 1 -> `quotient`=32'hFFFF_FFFF, `remainder`=0. Then 3 / 10 with `start` held continuously, back-to-back -> `quotient`=0, `remainder`=3, second `done` exactly 34 cycles after the first.
- 5 / 0 -> `quotient`=32'hFFFF_FFFF, `remainder`=5, `done` in the cycle after E1.
- 32'h8000_0000 / 2 with `start` dropped at E10 -> no `done`, outputs unchanged. Reissue -> `quotient`=32'h4000_0000, `remainder`=0.
- `rst_i` pulsed at E15 during 1000 / 3 -> all outputs 0, no `done`. Reissue -> `quotient`=333, `remainder`=1.
- `a31_bit_i`=1, `b31_bit_i`=0, operands change after E0 -> `a31_bit_o`=1, `b31_bit_o`=0, results computed from the E0 operands only.
